// File: rtl/maxpool2x2_engine.sv
// ---------------------------------------------------------------------------
// maxpool2x2_engine
//
// This block sits after the pooling register file. It reads a 4x4 activation
// tile from the register file and reduces it to four 2x2 max-pooled values.
// The values are emitted one window at a time over a valid/ready handshake.
//
// Ports:
//   clk, nrst    clock, asynchronous active-low reset
//   start        launch request (only sampled while idle)
//   busy         high whenever the engine is not idle
//   rd_adrs      register file read address (0 when not reading)
//   rd_data      register file read data, valid one cycle after rd_adrs
//   pool_data    max of the current window (the accumulator)
//   pool_idx     window index {row,col}: 0=TL 1=TR 2=BL 3=BR
//   pool_valid   pool_data / pool_idx valid
//   pool_ready   downstream accept
//   done         one-cycle pulse after window 3 is accepted
// ---------------------------------------------------------------------------
module maxpool2x2_engine #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int SIGNED     = 1
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  start,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] rd_adrs,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] pool_data,
    output logic [1:0]            pool_idx,
    output logic                  pool_valid,
    input  logic                  pool_ready,
    output logic                  done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_DRAIN = 3'd2,
        S_OUT   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [1:0]              w_q, w_d;            // window counter
    logic [1:0]              e_q, e_d;            // element currently being addressed
    logic [ADDR_WIDTH-1:0]   rd_adrs_q, rd_adrs_d;
    logic                    busy_q, busy_d;
    logic                    pool_valid_q, pool_valid_d;
    logic                    done_q, done_d;
    logic [DATA_WIDTH-1:0]   acc_q, acc_d;
    logic                    issued_q, issued_d;  // a read was issued last cycle
    logic                    first_q, first_d;    // ...and it was element 0
    logic                    rd_gt;

    // Window base = w[1]*8 + w[0]*2 and element offset = e[1]*4 + e[0].
    // Together they form the address bits {w[1], e[1], w[0], e[0]}.
    function automatic logic [ADDR_WIDTH-1:0] elem_addr(input logic [1:0] w,
                                                        input logic [1:0] e);
        logic [3:0] a;
        a = {w[1], e[1], w[0], e[0]};
        return ADDR_WIDTH'(a);
    endfunction

    always_comb begin
        if (SIGNED != 0)
            rd_gt = $signed(rd_data) > $signed(acc_q);
        else
            rd_gt = rd_data > acc_q;
    end

    always_comb begin
        state_d      = state_q;
        w_d          = w_q;
        e_d          = e_q;
        rd_adrs_d    = '0;
        pool_valid_d = 1'b0;
        done_d       = 1'b0;

        // The register file returns data one cycle after the address. The
        // capture therefore trails the READ state by one cycle. The capture
        // for element 3 lands in DRAIN.
        issued_d = (state_q == S_READ);
        first_d  = (state_q == S_READ) && (e_q == 2'd0);

        // Strict greater-than: on a tie the accumulator keeps its old value.
        acc_d = acc_q;
        if (issued_q && (first_q || rd_gt))
            acc_d = rd_data;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_READ;
                    w_d       = 2'd0;
                    e_d       = 2'd0;
                    rd_adrs_d = elem_addr(2'd0, 2'd0);
                end
            end
            S_READ: begin
                if (e_q == 2'd3) begin
                    state_d = S_DRAIN;
                end else begin
                    e_d       = e_q + 2'd1;
                    rd_adrs_d = elem_addr(w_q, e_q + 2'd1);
                end
            end
            S_DRAIN: begin
                state_d      = S_OUT;
                pool_valid_d = 1'b1;
            end
            S_OUT: begin
                pool_valid_d = 1'b1;
                if (pool_ready) begin
                    pool_valid_d = 1'b0;
                    if (w_q != 2'd3) begin
                        w_d       = w_q + 2'd1;
                        e_d       = 2'd0;
                        state_d   = S_READ;
                        rd_adrs_d = elem_addr(w_q + 2'd1, 2'd0);
                    end else begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                w_d     = 2'd0;
                e_d     = 2'd0;
            end
            default: begin
                state_d = S_IDLE;
                w_d     = 2'd0;
                e_d     = 2'd0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= S_IDLE;
            w_q          <= 2'd0;
            e_q          <= 2'd0;
            rd_adrs_q    <= '0;
            busy_q       <= 1'b0;
            pool_valid_q <= 1'b0;
            done_q       <= 1'b0;
            acc_q        <= '0;
            issued_q     <= 1'b0;
            first_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            w_q          <= w_d;
            e_q          <= e_d;
            rd_adrs_q    <= rd_adrs_d;
            busy_q       <= busy_d;
            pool_valid_q <= pool_valid_d;
            done_q       <= done_d;
            acc_q        <= acc_d;
            issued_q     <= issued_d;
            first_q      <= first_d;
        end
    end

    assign busy       = busy_q;
    assign rd_adrs    = rd_adrs_q;
    assign pool_data  = acc_q;
    assign pool_idx   = w_q;
    assign pool_valid = pool_valid_q;
    assign done       = done_q;

endmodule

// File: tb/tb_maxpool2x2_engine.sv
module tb_maxpool2x2_engine;

    typedef struct {
        logic [15:0][15:0] tile;
        logic [3:0][15:0]  exp_s;
        logic [3:0][15:0]  exp_u;
    } vec_t;

    typedef struct packed {
        logic [15:0] d;
        logic [1:0]  idx;
    } sb_t;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        start = 1'b0;
    logic        ready = 1'b1;
    logic        s_busy, u_busy, s_valid, u_valid, s_done, u_done;
    logic [3:0]  s_adrs, u_adrs;
    logic [15:0] s_rd, u_rd, s_data, u_data;
    logic [1:0]  s_idx, u_idx;
    logic [15:0] mem [16];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int base_g = 0;
    int n_out = 0;
    int hold_start = 0, poke_a = 0, poke_b = 0, stall_left = 0;
    logic [15:0] held_data;
    sb_t q_s[$], q_u[$];
    int acc_e[$];
    vec_t vecs[5];

    maxpool2x2_engine #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .SIGNED(1)) dut_s (
        .clk(clk), .nrst(nrst), .start(start), .busy(s_busy), .rd_adrs(s_adrs),
        .rd_data(s_rd), .pool_data(s_data), .pool_idx(s_idx), .pool_valid(s_valid),
        .pool_ready(ready), .done(s_done));

    maxpool2x2_engine #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .SIGNED(0)) dut_u (
        .clk(clk), .nrst(nrst), .start(start), .busy(u_busy), .rd_adrs(u_adrs),
        .rd_data(u_rd), .pool_data(u_data), .pool_idx(u_idx), .pool_valid(u_valid),
        .pool_ready(ready), .done(u_done));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // register file read port model: registered read
    always @(posedge clk) begin
        s_rd <= mem[s_adrs];
        u_rd <= mem[u_adrs];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // scoreboard: compare on each accepted transfer
    sb_t es, eu;
    always @(negedge clk) begin
        if (nrst && s_valid && ready) begin
            n_out++;
            acc_e.push_back(cyc + 1 - base_g);
            if (q_s.size() == 0) chk("s_unexpected_output", 1, 0);
            else begin
                es = q_s.pop_front();
                chk("s_pool_data", s_data, es.d);
                chk("s_pool_idx", s_idx, es.idx);
            end
        end
        if (nrst && u_valid && ready) begin
            if (q_u.size() == 0) chk("u_unexpected_output", 1, 0);
            else begin
                eu = q_u.pop_front();
                chk("u_pool_data", u_data, eu.d);
                chk("u_pool_idx", u_idx, eu.idx);
            end
        end
    end

    task automatic push_exp(input int v);
        for (int w = 0; w < 4; w++) begin
            q_s.push_back({vecs[v].exp_s[w], 2'(w)});
            q_u.push_back({vecs[v].exp_u[w], 2'(w)});
        end
    endtask

    task automatic load(input int v);
        for (int a = 0; a < 16; a++) mem[a] = vecs[v].tile[a];
    endtask

    // Runs cycles until done is seen; drives start pokes and the stall on window 1.
    task automatic wait_done(input int base, output int de);
        int first_stall;
        de = -1;
        first_stall = 1;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            start = (hold_start != 0) || (poke_a != 0 && cyc + 1 - base == poke_a) ||
                    (poke_b != 0 && cyc + 1 - base == poke_b);
            if (stall_left > 0 && s_valid && s_idx == 2'd1) begin
                ready = 1'b0;
                chk("stall_rd_adrs", s_adrs, 0);
                chk("stall_idx", s_idx, 1);
                if (first_stall) held_data = s_data;
                else chk("stall_data_stable", s_data, held_data);
                first_stall = 0;
                stall_left--;
            end else begin
                ready = 1'b1;
            end
            if (s_done) begin
                de = cyc - base;
                break;
            end
        end
        if (de < 0) chk("done_timeout", 0, 1);
    endtask

    task automatic run_tile(input int exp_done, input int a0, input int a1,
                            input int a2, input int a3);
        int base, de, out0;
        acc_e.delete();
        out0 = n_out;
        @(posedge clk); #1 start = 1'b1;
        base = cyc + 1;
        base_g = base;
        wait_done(base, de);
        chk("done_edge", de, exp_done);
        chk("busy_in_done", s_busy, 1);
        @(posedge clk); #1 start = 1'b0;
        chk("busy_after_done", s_busy, 0);
        chk("done_one_cycle", s_done, 0);
        @(posedge clk); #1;
        chk("stays_idle", s_busy, 0);
        chk("num_outputs", n_out - out0, 4);
        if (acc_e.size() == 4) begin
            chk("accept_e0", acc_e[0], a0);
            chk("accept_e1", acc_e[1], a1);
            chk("accept_e2", acc_e[2], a2);
            chk("accept_e3", acc_e[3], a3);
        end else chk("accept_count", acc_e.size(), 4);
        chk("sb_s_empty", q_s.size(), 0);
        chk("sb_u_empty", q_u.size(), 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, s_busy, 0);
        chk({tag, "_rd_adrs"}, s_adrs, 0);
        chk({tag, "_pool_data"}, s_data, 0);
        chk({tag, "_pool_idx"}, s_idx, 0);
        chk({tag, "_pool_valid"}, s_valid, 0);
        chk({tag, "_done"}, s_done, 0);
    endtask

    initial begin
        int de, base, out0;
        // vector table
        for (int v = 0; v < 5; v++) begin
            vecs[v].tile = '0; vecs[v].exp_s = '0; vecs[v].exp_u = '0;
        end
        for (int a = 0; a < 16; a++) begin
            vecs[0].tile[a] = 16'(a);
            vecs[2].tile[a] = 16'h1234;
            vecs[3].tile[a] = 16'(15 - a);
            vecs[4].tile[a] = 16'hFFF0 + 16'(a);
        end
        vecs[0].exp_s = {16'd15, 16'd13, 16'd7, 16'd5};
        vecs[0].exp_u = {16'd15, 16'd13, 16'd7, 16'd5};
        vecs[1].tile[0] = 16'h8000; vecs[1].tile[1] = 16'h0001;
        vecs[1].tile[4] = 16'hFFFF; vecs[1].tile[5] = 16'h0000;
        vecs[1].tile[2] = 16'h7FFF; vecs[1].tile[3] = 16'h8000;
        vecs[1].tile[6] = 16'h0000; vecs[1].tile[7] = 16'h0001;
        vecs[1].exp_s = {16'h0, 16'h0, 16'h7FFF, 16'h0001};
        vecs[1].exp_u = {16'h0, 16'h0, 16'h8000, 16'hFFFF};
        vecs[2].exp_s = {4{16'h1234}};
        vecs[2].exp_u = {4{16'h1234}};
        vecs[3].exp_s = {16'd5, 16'd7, 16'd13, 16'd15};
        vecs[3].exp_u = {16'd5, 16'd7, 16'd13, 16'd15};
        vecs[4].exp_s = {16'hFFFF, 16'hFFFD, 16'hFFF7, 16'hFFF5};
        vecs[4].exp_u = {16'hFFFF, 16'hFFFD, 16'hFFF7, 16'hFFF5};
        for (int a = 0; a < 16; a++) mem[a] = 16'h0;

        // reset state
        repeat (3) @(posedge clk);
        #1 chk_zero("reset");
        nrst = 1'b1;
        @(posedge clk); #1;

        // table-driven runs, ready always high
        for (int v = 0; v < 5; v++) begin
            load(v);
            push_exp(v);
            run_tile(24, 6, 12, 18, 24);
        end

        // backpressure: 5 stall cycles on window 1
        load(0); push_exp(0);
        stall_left = 5;
        run_tile(29, 6, 17, 23, 29);
        chk("stall_consumed", stall_left, 0);

        // start pulses during READ of window 2 and during DONE are ignored
        load(3); push_exp(3);
        poke_a = 14; poke_b = 25;
        run_tile(24, 6, 12, 18, 24);
        poke_a = 0; poke_b = 0;

        // start held high: relaunch from the IDLE cycle after done
        load(2); push_exp(2); push_exp(2);
        out0 = n_out;
        hold_start = 1;
        @(posedge clk); #1 start = 1'b1;
        base = cyc + 1; base_g = base;
        wait_done(base, de);
        chk("held_done_edge", de, 24);
        @(posedge clk); #1;
        chk("held_idle_after_done", s_busy, 0);
        @(posedge clk); #1;
        chk("held_relaunch_busy", s_busy, 1);
        hold_start = 0; start = 1'b0;
        base = base + 26; base_g = base;
        wait_done(base, de);
        chk("held_second_done_edge", de, 24);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("held_final_idle", s_busy, 0);
        chk("held_num_outputs", n_out - out0, 8);

        // asynchronous reset in the middle of window 1 READ
        load(0); push_exp(0);
        @(posedge clk); #1 start = 1'b1;
        base = cyc + 1; base_g = base;
        @(posedge clk); #1 start = 1'b0;
        repeat (8) @(posedge clk);
        #1 chk("pre_reset_busy", s_busy, 1);
        chk("pre_reset_rd_adrs", s_adrs, 4'd6);
        nrst = 1'b0;
        #1 chk_zero("midreset");
        chk("midreset_pending", q_s.size(), 3);
        q_s.delete(); q_u.delete();
        @(posedge clk); #1 nrst = 1'b1;
        @(posedge clk); #1;
        load(0); push_exp(0);
        run_tile(24, 6, 12, 18, 24);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
